// File: rtl/input_handshake.sv
// Input-instruction handshake: stalls the processor until the user confirms a
// switch word with a debounced Key press/release, then pulses Ready for one cycle.
module input_handshake #(
    parameter logic [19:0] DB_CYCLES = 20'd50000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InReq,
    input  logic [15:0] Switches,
    input  logic        Key,
    output logic [31:0] DataIO,
    output logic        Halt,
    output logic        Ready
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] WAIT_PRESS   = 2'd1;
    localparam logic [1:0] WAIT_RELEASE = 2'd2;
    localparam logic [1:0] DONE         = 2'd3;

    logic        rst_meta;
    logic        rst_n;
    logic        key_meta;
    logic        key_s;
    logic        key_d;
    logic [19:0] db_count;
    logic        key_flip;
    logic        press_evt;
    logic        release_evt;
    logic [1:0]  state;
    logic [1:0]  next_state;

    // Reset asserts immediately but releases on a Clock edge, so no flop sees
    // a release racing the clock.
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    // Synchronizer resets to "released" so the first cycles after reset
    // cannot look like a press.
    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
        end else begin
            key_meta <= Key;
            key_s    <= key_meta;
        end
    end

    // The flip is decided combinationally so the capture lands on the same
    // edge that updates key_d.
    assign key_flip    = (key_s != key_d) && (db_count >= DB_CYCLES - 20'd1);
    assign press_evt   = key_flip && key_d;
    assign release_evt = key_flip && !key_d;

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            key_d    <= 1'b1;
            db_count <= '0;
        end else if (key_s == key_d) begin
            db_count <= '0;
        end else if (key_flip) begin
            key_d    <= key_s;
            db_count <= '0;
        end else if (db_count != '1) begin
            db_count <= db_count + 20'd1;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:         if (InReq)       next_state = WAIT_PRESS;
            WAIT_PRESS:   if (press_evt)   next_state = WAIT_RELEASE;
            WAIT_RELEASE: if (release_evt) next_state = DONE;
            DONE:                          next_state = IDLE;
            default:                       next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            DataIO <= '0;
        end else begin
            state <= next_state;
            if (state == WAIT_PRESS && press_evt)
                DataIO <= {16'h0000, Switches};
        end
    end

    assign Halt  = (state == WAIT_PRESS) || (state == WAIT_RELEASE);
    assign Ready = (state == DONE);

endmodule
